// File: rtl/video_timing_gen_pkg.sv
// video_timing_gen_pkg
// Raster geometry for the HDMI output path. Holds the 480p and 720p timing
// sets and the selected default configuration the timing generator picks up
// as its parameter defaults, plus the power-up state type.
package video_timing_gen_pkg;

  typedef enum logic [0:0] {
    POWERUP = 1'b0,
    RUN     = 1'b1
  } vtg_state_e;

  // 480p (720x480 active, 858x525 total, 3x upscale of 240x160)
  localparam int   FRAMEWIDTH_480   = 720;
  localparam int   FRAMEHEIGHT_480  = 480;
  localparam int   TOTALWIDTH_480   = 858;
  localparam int   TOTALHEIGHT_480  = 525;
  localparam int   H_FRONT_480      = 16;
  localparam int   H_SYNC_480       = 62;
  localparam int   H_BACK_480       = 60;
  localparam int   V_FRONT_480      = 9;
  localparam int   V_SYNC_480       = 6;
  localparam int   V_BACK_480       = 30;
  localparam logic HSYNC_POL_480    = 1'b0;
  localparam logic VSYNC_POL_480    = 1'b0;
  localparam int   SCALE_480        = 3;

  // 720p (1280x720 active, 1650x750 total, 5x upscale of 256x144)
  localparam int   FRAMEWIDTH_720   = 1280;
  localparam int   FRAMEHEIGHT_720  = 720;
  localparam int   TOTALWIDTH_720   = 1650;
  localparam int   TOTALHEIGHT_720  = 750;
  localparam int   H_FRONT_720      = 110;
  localparam int   H_SYNC_720       = 40;
  localparam int   H_BACK_720       = 220;
  localparam int   V_FRONT_720      = 5;
  localparam int   V_SYNC_720       = 5;
  localparam int   V_BACK_720       = 20;
  localparam logic HSYNC_POL_720    = 1'b1;
  localparam logic VSYNC_POL_720    = 1'b1;
  localparam int   SCALE_720        = 5;

  // Selected configuration
  localparam int   FRAMEWIDTH       = FRAMEWIDTH_480;
  localparam int   FRAMEHEIGHT      = FRAMEHEIGHT_480;
  localparam int   TOTALWIDTH       = TOTALWIDTH_480;
  localparam int   TOTALHEIGHT      = TOTALHEIGHT_480;
  localparam int   CFG_H_FRONT      = H_FRONT_480;
  localparam int   CFG_H_SYNC       = H_SYNC_480;
  localparam int   CFG_V_FRONT      = V_FRONT_480;
  localparam int   CFG_V_SYNC       = V_SYNC_480;
  localparam logic CFG_HSYNC_POL    = HSYNC_POL_480;
  localparam logic CFG_VSYNC_POL    = VSYNC_POL_480;
  localparam int   CFG_SCALE        = SCALE_480;
  localparam int   SRC_WIDTH        = FRAMEWIDTH / CFG_SCALE;
  localparam int   SRC_HEIGHT       = FRAMEHEIGHT / CFG_SCALE;
  localparam int   POWERUPCYCLES    = 1000000;

endpackage

// File: rtl/video_timing_gen_scale_counter.sv
// video_timing_gen_scale_counter
// Divider-free cx/SCALE style counter: a modulo-SCALE sub-counter and a
// quotient counter that steps whenever the sub-counter wraps.
// Ports:
//   clk, resetn    : clock, synchronous active-low reset
//   clr            : restart both counters at 0 on this edge (wins over adv)
//   adv            : advance the sub-counter by one on this edge
//   q              : registered quotient
//   sub_zero_nxt   : the sub-counter value being loaded this edge is 0
module video_timing_gen_scale_counter #(
  parameter int SCALE = 1,
  parameter int QW    = 9
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          adv,
  output logic [QW-1:0] q,
  output logic          sub_zero_nxt
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [SW-1:0] sub_r;
  logic [SW-1:0] sub_nxt_s;
  logic [QW-1:0] q_nxt_s;

  // Next sub/quotient values; with SCALE=1 the sub-counter is stuck at 0.
  always_comb begin
    sub_nxt_s = sub_r;
    q_nxt_s   = q;
    if (clr) begin
      sub_nxt_s = {SW{1'b0}};
      q_nxt_s   = {QW{1'b0}};
    end else if (adv) begin
      if (sub_r == SW'(SCALE - 1)) begin
        sub_nxt_s = {SW{1'b0}};
        q_nxt_s   = q + QW'(1);
      end else begin
        sub_nxt_s = sub_r + SW'(1);
        q_nxt_s   = q;
      end
    end else begin
      sub_nxt_s = sub_r;
      q_nxt_s   = q;
    end
  end

  assign sub_zero_nxt = (sub_nxt_s == {SW{1'b0}});

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sub_r <= {SW{1'b0}};
      q     <= {QW{1'b0}};
    end else begin
      sub_r <= sub_nxt_s;
      q     <= q_nxt_s;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Pixel-clock raster generator. After a power-up hold-off it sweeps an
// H_TOTAL x V_TOTAL raster and emits active-video enable, syncs, the raster
// coordinates and the 1/SCALE source coordinates for the framebuffer reader.
// Every output is registered from the same next-state values, so all of them
// describe the same pixel as cx/cy.
// Ports:
//   clk_pixel, resetn : pixel clock, synchronous active-low reset
//   ready             : hold-off elapsed, raster running
//   cx, cy            : raster counters
//   de                : active video
//   hsync, vsync      : syncs, polarity HSYNC_POL / VSYNC_POL
//   sx, sy            : source coordinates (meaningful while de)
//   src_new           : first output pixel of a new source pixel
//   frame_start       : pulse at cx=0, cy=0
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE       = FRAMEWIDTH,
  parameter int   V_ACTIVE       = FRAMEHEIGHT,
  parameter int   H_TOTAL        = TOTALWIDTH,
  parameter int   V_TOTAL        = TOTALHEIGHT,
  parameter int   H_FRONT        = CFG_H_FRONT,
  parameter int   H_SYNC         = CFG_H_SYNC,
  parameter int   V_FRONT        = CFG_V_FRONT,
  parameter int   V_SYNC         = CFG_V_SYNC,
  parameter logic HSYNC_POL      = CFG_HSYNC_POL,
  parameter logic VSYNC_POL      = CFG_VSYNC_POL,
  parameter int   SCALE          = CFG_SCALE,
  parameter int   POWERUP_CYCLES = POWERUPCYCLES
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  output logic        ready,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [8:0]  sx,
  output logic [7:0]  sy,
  output logic        src_new,
  output logic        frame_start
);

  vtg_state_e  state_r;
  vtg_state_e  state_nxt_s;
  logic [31:0] pu_cnt_r;
  logic [31:0] pu_cnt_nxt_s;
  logic        run_nxt_s;
  logic [11:0] cx_nxt_s;
  logic [10:0] cy_nxt_s;
  logic        h_act_s;
  logic        v_act_s;
  logic        de_nxt_s;
  logic        hsync_nxt_s;
  logic        vsync_nxt_s;
  logic        x_clr_s;
  logic        y_clr_s;
  logic        y_adv_s;
  logic        x_sub_zero_s;
  logic        y_sub_zero_s;

  // Power-up hold-off and raster counter next-state.
  always_comb begin
    state_nxt_s  = state_r;
    pu_cnt_nxt_s = pu_cnt_r;
    run_nxt_s    = 1'b0;
    cx_nxt_s     = 12'd0;
    cy_nxt_s     = 11'd0;
    case (state_r)
      POWERUP: begin
        // The count equals the number of released edges seen so far, so the
        // raster starts on edge POWERUP_CYCLES+1 after reset is released.
        if (pu_cnt_r == 32'(POWERUP_CYCLES)) begin
          state_nxt_s = RUN;
          run_nxt_s   = 1'b1;
        end else begin
          pu_cnt_nxt_s = pu_cnt_r + 32'd1;
          run_nxt_s    = 1'b0;
        end
      end
      RUN: begin
        run_nxt_s = 1'b1;
        if (cx == 12'(H_TOTAL - 1)) begin
          cx_nxt_s = 12'd0;
          if (cy == 11'(V_TOTAL - 1)) begin
            cy_nxt_s = 11'd0;
          end else begin
            cy_nxt_s = cy + 11'd1;
          end
        end else begin
          cx_nxt_s = cx + 12'd1;
          cy_nxt_s = cy;
        end
      end
      default: begin
        state_nxt_s = POWERUP;
      end
    endcase
  end

  assign h_act_s     = (cx_nxt_s < 12'(H_ACTIVE));
  assign v_act_s     = (cy_nxt_s < 11'(V_ACTIVE));
  assign de_nxt_s    = run_nxt_s && h_act_s && v_act_s;
  assign hsync_nxt_s = (run_nxt_s && (cx_nxt_s >= 12'(H_ACTIVE + H_FRONT))
                        && (cx_nxt_s < 12'(H_ACTIVE + H_FRONT + H_SYNC)))
                       ? HSYNC_POL : ~HSYNC_POL;
  // Line-granular: depends on cy only, so it switches together with cx=0.
  assign vsync_nxt_s = (run_nxt_s && (cy_nxt_s >= 11'(V_ACTIVE + V_FRONT))
                        && (cy_nxt_s < 11'(V_ACTIVE + V_FRONT + V_SYNC)))
                       ? VSYNC_POL : ~VSYNC_POL;

  // Source x restarts every line and freezes past the active width; source y
  // restarts every frame and advances once per active line.
  assign x_clr_s = !run_nxt_s || (cx_nxt_s == 12'd0);
  assign y_clr_s = !run_nxt_s || ((cx_nxt_s == 12'd0) && (cy_nxt_s == 11'd0));
  assign y_adv_s = (cx_nxt_s == 12'd0) && v_act_s;

  video_timing_gen_scale_counter #(.SCALE(SCALE), .QW(9)) u_x_scale (
    .clk          (clk_pixel),
    .resetn       (resetn),
    .clr          (x_clr_s),
    .adv          (h_act_s),
    .q            (sx),
    .sub_zero_nxt (x_sub_zero_s)
  );

  video_timing_gen_scale_counter #(.SCALE(SCALE), .QW(8)) u_y_scale (
    .clk          (clk_pixel),
    .resetn       (resetn),
    .clr          (y_clr_s),
    .adv          (y_adv_s),
    .q            (sy),
    .sub_zero_nxt (y_sub_zero_s)
  );

  // State, hold-off counter and registered raster outputs.
  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      state_r     <= POWERUP;
      pu_cnt_r    <= 32'd0;
      ready       <= 1'b0;
      cx          <= 12'd0;
      cy          <= 11'd0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      src_new     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pu_cnt_r    <= pu_cnt_nxt_s;
      ready       <= run_nxt_s;
      cx          <= cx_nxt_s;
      cy          <= cy_nxt_s;
      de          <= de_nxt_s;
      hsync       <= hsync_nxt_s;
      vsync       <= vsync_nxt_s;
      src_new     <= de_nxt_s && x_sub_zero_s;
      frame_start <= run_nxt_s && (cx_nxt_s == 12'd0) && (cy_nxt_s == 11'd0);
    end
  end

endmodule
